// File: rtl/imo_cmd_arbiter_pkg.sv
// imo_cmd_arbiter_pkg: shared encodings and helpers for the host/IMO command arbiter.
`ifndef INT_CMD_SZ
`define INT_CMD_SZ 4
`endif

package imo_cmd_arbiter_pkg;

    // Width of the internal DRAM command code carried on both request ports.
    localparam int unsigned INT_CMD_SZ = `INT_CMD_SZ;

    // Arbiter FSM: pick a winner, hold it on the scheduler port, pulse the ack.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

    // Source IDs as reported on sch_src.
    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_IMO  = 1'b1;

    // Smallest counter width able to hold max_val (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/imo_arb_pick.sv
// imo_arb_pick: winner selection plus the starvation and lock-ownership bookkeeping.
module imo_arb_pick
    import imo_cmd_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT     = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_idle,
    input  logic host_valid,
    input  logic arb_valid,
    input  logic imo_lock,
    input  logic imo_ack_done,
    output logic grant_c,
    output logic src_c,
    output logic lock_err
);

    localparam int unsigned WAIT_W = cnt_w(MAX_WAIT);
    localparam int unsigned LOCK_W = cnt_w(LOCK_TIMEOUT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              locked;
    logic              wait_hit_c;
    logic              lock_hit_c;
    logic              req_c;

    assign wait_hit_c = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign lock_hit_c = locked && (lock_cnt == LOCK_W'(LOCK_TIMEOUT));

    // Priority: lock owner, starved IMO, host, then IMO; grants only land in IDLE.
    // A held lock still applies in the cycle it times out; host wins from the next IDLE.
    always_comb begin
        req_c   = 1'b0;
        src_c   = SRC_HOST;
        grant_c = 1'b0;
        if (locked) begin
            req_c = arb_valid;
            src_c = SRC_IMO;
        end else if (arb_valid && wait_hit_c) begin
            req_c = 1'b1;
            src_c = SRC_IMO;
        end else if (host_valid) begin
            req_c = 1'b1;
            src_c = SRC_HOST;
        end else if (arb_valid) begin
            req_c = 1'b1;
            src_c = SRC_IMO;
        end
        grant_c = in_idle && req_c;
    end

    // Starvation counter: counts IDLE cycles where IMO waits behind a host grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (in_idle) begin
            if (!arb_valid || (grant_c && (src_c == SRC_IMO))) begin
                wait_cnt <= '0;
            end else if (grant_c && !wait_hit_c) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Lock ownership: taken at an IMO ack, dropped by imo_lock low in IDLE or by timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
            lock_err <= 1'b0;
        end else if (imo_ack_done) begin
            locked   <= imo_lock;
            lock_cnt <= '0;
        end else if (lock_hit_c) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
            lock_err <= 1'b1;
        end else if (locked && in_idle && !imo_lock) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else if (locked) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
        end
    end

endmodule

// File: rtl/imo_cmd_arbiter.sv
// imo_cmd_arbiter: shares the DRAM command-scheduler port between host and imo_controller.
module imo_cmd_arbiter
    import imo_cmd_arbiter_pkg::*;
#(
    parameter int unsigned CMD_W        = INT_CMD_SZ,
    parameter int unsigned ADDR_W       = 60,
    parameter int unsigned MAX_WAIT     = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [CMD_W-1:0]  host_cmd,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    input  logic              arb_valid,
    input  logic [CMD_W-1:0]  arb_cmd,
    input  logic [ADDR_W-1:0] arb_addr,
    output logic              arb_ack,
    input  logic              imo_lock,
    output logic              sch_valid,
    output logic [CMD_W-1:0]  sch_cmd,
    output logic [ADDR_W-1:0] sch_addr,
    output logic              sch_src,
    input  logic              sch_ready,
    output logic              lock_err
);

    arb_state_e state;
    logic       in_idle_c;
    logic       imo_ack_c;
    logic       grant_c;
    logic       src_c;

    assign in_idle_c = (state == ST_IDLE);
    assign imo_ack_c = (state == ST_ACK) && (sch_src == SRC_IMO);

    imo_arb_pick #(
        .MAX_WAIT     (MAX_WAIT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_pick (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_idle      (in_idle_c),
        .host_valid   (host_valid),
        .arb_valid    (arb_valid),
        .imo_lock     (imo_lock),
        .imo_ack_done (imo_ack_c),
        .grant_c      (grant_c),
        .src_c        (src_c),
        .lock_err     (lock_err)
    );

    // FSM with registered scheduler port and ack pulses; payload captured at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sch_valid <= 1'b0;
            sch_cmd   <= '0;
            sch_addr  <= '0;
            sch_src   <= SRC_HOST;
            host_ack  <= 1'b0;
            arb_ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        sch_valid <= 1'b1;
                        sch_src   <= src_c;
                        sch_cmd   <= (src_c == SRC_IMO) ? arb_cmd  : host_cmd;
                        sch_addr  <= (src_c == SRC_IMO) ? arb_addr : host_addr;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sch_ready) begin
                        sch_valid <= 1'b0;
                        host_ack  <= (sch_src == SRC_HOST);
                        arb_ack   <= (sch_src == SRC_IMO);
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    host_ack <= 1'b0;
                    arb_ack  <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    sch_valid <= 1'b0;
                    host_ack  <= 1'b0;
                    arb_ack   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imo_cmd_arbiter.sv
// tb_imo_cmd_arbiter: vector table plus directed multi-cycle sequences for imo_cmd_arbiter.
module tb_imo_cmd_arbiter;
    import imo_cmd_arbiter_pkg::*;

    localparam int unsigned CMD_W        = INT_CMD_SZ;
    localparam int unsigned ADDR_W       = 60;
    localparam int unsigned MAX_WAIT     = 4;
    localparam int unsigned LOCK_TIMEOUT = 8;
    localparam int          NVEC         = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_valid;
    logic [CMD_W-1:0]  host_cmd;
    logic [ADDR_W-1:0] host_addr;
    logic              host_ack;
    logic              arb_valid;
    logic [CMD_W-1:0]  arb_cmd;
    logic [ADDR_W-1:0] arb_addr;
    logic              arb_ack;
    logic              imo_lock;
    logic              sch_valid;
    logic [CMD_W-1:0]  sch_cmd;
    logic [ADDR_W-1:0] sch_addr;
    logic              sch_src;
    logic              sch_ready;
    logic              lock_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester model state for the directed sequences.
    int host_left = 0;
    int arb_left  = 0;
    int lock_mode = 0;   // 0: imo_lock low, 1: high while IMO work remains, 2: forced high
    int addr_skew = 0;
    int log_src[$];
    int wait_at_imo_ack = -1;

    typedef struct packed {
        logic              hv;
        logic [CMD_W-1:0]  hc;
        logic [ADDR_W-1:0] ha;
        logic              av;
        logic [CMD_W-1:0]  ac;
        logic [ADDR_W-1:0] aa;
        logic              rdy;
        logic              e_sv;
        logic              e_src;
        logic [CMD_W-1:0]  e_cmd;
        logic [ADDR_W-1:0] e_addr;
        logic              e_hack;
        logic              e_aack;
    } vec_t;

    vec_t vecs [NVEC];

    imo_cmd_arbiter #(
        .CMD_W        (CMD_W),
        .ADDR_W       (ADDR_W),
        .MAX_WAIT     (MAX_WAIT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_cmd   (host_cmd),
        .host_addr  (host_addr),
        .host_ack   (host_ack),
        .arb_valid  (arb_valid),
        .arb_cmd    (arb_cmd),
        .arb_addr   (arb_addr),
        .arb_ack    (arb_ack),
        .imo_lock   (imo_lock),
        .sch_valid  (sch_valid),
        .sch_cmd    (sch_cmd),
        .sch_addr   (sch_addr),
        .sch_src    (sch_src),
        .sch_ready  (sch_ready),
        .lock_err   (lock_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int hv, input int hc, input longint ha,
                                input int av, input int ac, input longint aa,
                                input int rdy, input int e_sv, input int e_src,
                                input int e_cmd, input longint e_addr,
                                input int e_hack, input int e_aack);
        vec_t v;
        v.hv     = (hv != 0);
        v.hc     = CMD_W'(hc);
        v.ha     = ADDR_W'(ha);
        v.av     = (av != 0);
        v.ac     = CMD_W'(ac);
        v.aa     = ADDR_W'(aa);
        v.rdy    = (rdy != 0);
        v.e_sv   = (e_sv != 0);
        v.e_src  = (e_src != 0);
        v.e_cmd  = CMD_W'(e_cmd);
        v.e_addr = ADDR_W'(e_addr);
        v.e_hack = (e_hack != 0);
        v.e_aack = (e_aack != 0);
        return v;
    endfunction

    task automatic drive_reqs();
        host_valid = (host_left > 0);
        host_cmd   = CMD_W'(host_left);
        host_addr  = ADDR_W'(64'h0000_ABC0 + 64'(host_left + addr_skew));
        arb_valid  = (arb_left > 0);
        arb_cmd    = CMD_W'(arb_left + 8);
        arb_addr   = ADDR_W'(64'h0000_D000 + 64'(arb_left));
        case (lock_mode)
            1:       imo_lock = (arb_left > 0);
            2:       imo_lock = 1'b1;
            default: imo_lock = 1'b0;
        endcase
    endtask

    // One clock; requesters retire a request on its ack and present the next one.
    task automatic tick();
        @(posedge clk);
        #1;
        if (host_ack) begin
            log_src.push_back(0);
            host_left--;
        end
        if (arb_ack) begin
            log_src.push_back(1);
            arb_left--;
            wait_at_imo_ack = int'(dut.u_pick.wait_cnt);
        end
        drive_reqs();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((host_left > 0 || arb_left > 0) && n < 200) begin
            tick();
            n++;
        end
        check({name, " drained"}, 64'(host_left + arb_left), 64'd0);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        host_left = 0;
        arb_left  = 0;
        lock_mode = 0;
        addr_skew = 0;
        sch_ready = 1'b1;
        drive_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        log_src.delete();
    endtask

    initial begin
        // Single IMO request, then host/IMO contention with no lock.
        vecs[0]  = mk(0, 0, 0,      1, 1, 'h123, 1,  1, 1, 1, 'h123, 0, 0);
        vecs[1]  = mk(0, 0, 0,      1, 1, 'h123, 1,  0, 1, 1, 'h123, 0, 1);
        vecs[2]  = mk(0, 0, 0,      0, 0, 0,     1,  0, 1, 1, 'h123, 0, 0);
        vecs[3]  = mk(0, 0, 0,      0, 0, 0,     1,  0, 1, 1, 'h123, 0, 0);
        vecs[4]  = mk(1, 2, 'hAAA,  1, 3, 'hBBB, 1,  1, 0, 2, 'hAAA, 0, 0);
        vecs[5]  = mk(1, 2, 'hAAA,  1, 3, 'hBBB, 1,  0, 0, 2, 'hAAA, 1, 0);
        vecs[6]  = mk(0, 0, 0,      1, 3, 'hBBB, 1,  0, 0, 2, 'hAAA, 0, 0);
        vecs[7]  = mk(0, 0, 0,      1, 3, 'hBBB, 1,  1, 1, 3, 'hBBB, 0, 0);
        vecs[8]  = mk(0, 0, 0,      1, 3, 'hBBB, 1,  0, 1, 3, 'hBBB, 0, 1);
        vecs[9]  = mk(0, 0, 0,      0, 0, 0,     1,  0, 1, 3, 'hBBB, 0, 0);
        vecs[10] = mk(0, 0, 0,      0, 0, 0,     1,  0, 1, 3, 'hBBB, 0, 0);

        do_reset();
        check("reset sch_valid", 64'(sch_valid), 64'd0);
        check("reset sch_cmd",   64'(sch_cmd),   64'd0);
        check("reset sch_addr",  64'(sch_addr),  64'd0);
        check("reset sch_src",   64'(sch_src),   64'd0);
        check("reset host_ack",  64'(host_ack),  64'd0);
        check("reset arb_ack",   64'(arb_ack),   64'd0);
        check("reset lock_err",  64'(lock_err),  64'd0);

        for (int i = 0; i < NVEC; i++) begin
            host_valid = vecs[i].hv;
            host_cmd   = vecs[i].hc;
            host_addr  = vecs[i].ha;
            arb_valid  = vecs[i].av;
            arb_cmd    = vecs[i].ac;
            arb_addr   = vecs[i].aa;
            imo_lock   = 1'b0;
            sch_ready  = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d sch_valid", i), 64'(sch_valid), 64'(vecs[i].e_sv));
            check($sformatf("vec%0d sch_src", i),   64'(sch_src),   64'(vecs[i].e_src));
            check($sformatf("vec%0d sch_cmd", i),   64'(sch_cmd),   64'(vecs[i].e_cmd));
            check($sformatf("vec%0d sch_addr", i),  64'(sch_addr),  64'(vecs[i].e_addr));
            check($sformatf("vec%0d host_ack", i),  64'(host_ack),  64'(vecs[i].e_hack));
            check($sformatf("vec%0d arb_ack", i),   64'(arb_ack),   64'(vecs[i].e_aack));
        end

        // Starvation: host wins four times, then IMO is forced in at wait_cnt == 4.
        do_reset();
        host_left = 6;
        arb_left  = 1;
        drive_reqs();
        drain("starve");
        check("starve grant count", 64'(log_src.size()), 64'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("starve grant%0d src", i),
                  64'((i < log_src.size()) ? log_src[i] : -1), 64'((i == 4) ? 1 : 0));
        end
        check("starve wait_cnt after imo grant", 64'(wait_at_imo_ack), 64'd0);

        // Lock: three back-to-back IMO commands, host only after the lock is dropped.
        do_reset();
        lock_mode = 1;
        arb_left  = 3;
        drive_reqs();
        tick();
        check("lock first grant src", 64'(sch_src), 64'd1);
        host_left = 1;
        drive_reqs();
        drain("lock");
        check("lock grant count", 64'(log_src.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lock grant%0d src", i),
                  64'((i < log_src.size()) ? log_src[i] : -1), 64'((i < 3) ? 1 : 0));
        end
        check("lock no timeout", 64'(lock_err), 64'd0);

        // Lock timeout: IMO holds the lock with nothing to send; host gets in after it expires.
        do_reset();
        lock_mode = 2;
        arb_left  = 1;
        drive_reqs();
        tick();
        check("tmo imo sch_valid", 64'(sch_valid), 64'd1);
        check("tmo imo sch_src",   64'(sch_src),   64'd1);
        host_left = 1;
        drive_reqs();
        tick();
        check("tmo imo arb_ack", 64'(arb_ack), 64'd1);
        tick();
        for (int i = 0; i < int'(LOCK_TIMEOUT); i++) begin
            tick();
            check($sformatf("tmo hold%0d sch_valid", i), 64'(sch_valid), 64'd0);
        end
        check("tmo lock_err before expiry", 64'(lock_err), 64'd0);
        tick();
        check("tmo lock_err at expiry", 64'(lock_err), 64'd1);
        check("tmo no grant at expiry", 64'(sch_valid), 64'd0);
        tick();
        check("tmo host sch_valid", 64'(sch_valid), 64'd1);
        check("tmo host sch_src",   64'(sch_src),   64'd0);
        lock_mode = 0;
        drive_reqs();
        drain("tmo");
        check("tmo lock_err sticky", 64'(lock_err), 64'd1);
        do_reset();
        check("tmo lock_err cleared by reset", 64'(lock_err), 64'd0);

        // Backpressure: payload held while sch_ready is low even as host inputs change.
        sch_ready = 1'b0;
        host_left = 1;
        drive_reqs();
        tick();
        check("bp sch_valid", 64'(sch_valid), 64'd1);
        check("bp sch_addr",  64'(sch_addr),  64'h0000_ABC1);
        addr_skew = 256;
        drive_reqs();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp hold%0d sch_valid", i), 64'(sch_valid), 64'd1);
            check($sformatf("bp hold%0d sch_addr", i),  64'(sch_addr),  64'h0000_ABC1);
            check($sformatf("bp hold%0d sch_cmd", i),   64'(sch_cmd),   64'd1);
            check($sformatf("bp hold%0d host_ack", i),  64'(host_ack),  64'd0);
        end
        sch_ready = 1'b1;
        tick();
        check("bp release host_ack",  64'(host_ack),  64'd1);
        check("bp release sch_valid", 64'(sch_valid), 64'd0);
        addr_skew = 0;
        drive_reqs();
        drain("bp");

        // Reset mid-ISSUE: command dropped at once, no ack afterwards.
        sch_ready = 1'b0;
        host_left = 1;
        drive_reqs();
        tick();
        check("rst pre sch_valid", 64'(sch_valid), 64'd1);
        #2;
        rst_n     = 1'b0;
        host_left = 0;
        drive_reqs();
        #1;
        check("rst async sch_valid", 64'(sch_valid), 64'd0);
        check("rst async host_ack",  64'(host_ack),  64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        sch_ready = 1'b1;
        log_src.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rst after%0d acks", i), 64'(host_ack | arb_ack), 64'd0);
            check($sformatf("rst after%0d sch_valid", i), 64'(sch_valid), 64'd0);
        end
        check("rst no grants logged", 64'(log_src.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imo_cmd_arbiter.md
Name: imo_cmd_arbiter

Overview:
Shares the single DRAM command-scheduler port between two requesters: the host memory-request path and imo_controller (arb_cmd/arb_valid/arb_addr/arb_ack).
- Host traffic has priority.
- A starvation counter guarantees IMO progress.
- A lock keeps multi-command IMO sequences (e.g. RowClone ACT-ACT-PRE) contiguous.
- Sits between imo_controller and the command scheduler inside the PiDRAM memory controller.

Parameters:
- CMD_W, `INT_CMD_SZ, width of internal command code.
- ADDR_W, 60, request address width.
- MAX_WAIT, 16, cycles a pending non-priority requester waits before forced grant; legal range 1..255.
- LOCK_TIMEOUT, 1024, maximum cycles imo_lock may hold ownership after an ack.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- host_valid, in, 1, host request pending; held until host_ack.
- host_cmd, in, CMD_W, host command.
- host_addr, in, ADDR_W, host address.
- host_ack, out, 1, one-cycle accept pulse.
- arb_valid, in, 1, IMO request pending; held until arb_ack.
- arb_cmd, in, CMD_W, IMO command.
- arb_addr, in, ADDR_W, IMO address.
- arb_ack, out, 1, one-cycle accept pulse.
- imo_lock, in, 1, IMO keeps ownership after its current ack.
- sch_valid, out, 1, command to scheduler valid.
- sch_cmd, out, CMD_W, registered command.
- sch_addr, out, ADDR_W, registered address.
- sch_src, out, 1, 0 = host, 1 = IMO.
- sch_ready, in, 1, scheduler accepts when sch_valid & sch_ready.
- lock_err, out, 1, sticky: lock timeout occurred.

Behaviour:
- Reset (async on rst_n low):
  - all outputs 0, FSM IDLE, counters 0, owner = none.
  - Reset mid-ISSUE drops the command; no ack is issued.
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - Evaluate requests each cycle.
  - Latch winner's cmd/addr into sch_cmd/sch_addr, set sch_src.
  - Next cycle: sch_valid=1 and go to ISSUE.
- Winner selection, in priority order:
  - (a) locked owner IMO and arb_valid -> IMO; while locked, host is never granted.
  - (b) wait_cnt == MAX_WAIT and arb_valid -> IMO.
  - (c) host_valid -> host.
  - (d) arb_valid -> IMO.
  - (e) none -> stay IDLE.
- ISSUE:
  - sch_valid, sch_cmd, sch_addr and sch_src are held stable until sch_ready.
  - On sch_valid & sch_ready: sch_valid=0 next cycle, go to ACK.
- ACK:
  - Exactly one-cycle pulse on host_ack or arb_ack for the granted source, then IDLE.
  - Requesters drop valid during the ack cycle.
  - IDLE re-evaluates on the cycle after ACK, so a requester cannot be double-granted from a stale valid.
- Latency with sch_ready tied high: valid sampled at edge N, sch_valid high at N+1, ack high at N+2. Minimum 3 cycles per command.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) in each IDLE cycle where arb_valid=1 and host wins.
  - Clears when IMO is granted or arb_valid=0.
  - Frozen outside IDLE.
- Lock:
  - If imo_lock=1 during the arb_ack cycle, owner = IMO and lock_cnt starts at 0.
  - lock_cnt increments each cycle while locked.
  - Lock releases when imo_lock=0 is sampled in IDLE.
  - Lock also releases when lock_cnt reaches LOCK_TIMEOUT; this sets lock_err (sticky until reset), and host is granted normally from the next IDLE.
  - While locked and arb_valid=0, the arbiter idles; host waits.
- Simultaneous host_valid & arb_valid with no lock and wait_cnt < MAX_WAIT: host wins.
- sch_ready asserted while not in ISSUE: ignored.
- Input changes during ISSUE or ACK: ignored, since cmd/addr are registered.

Decomposition:
- Shared package / encoding.vh:
  - `INT_CMD_SZ.
  - FSM state encoding localparams.
  - Source IDs SRC_HOST=0, SRC_IMO=1.
- One natural sub-module, imo_arb_pick: combinational winner selection plus wait_cnt/lock_cnt registers, outputting grant and src.
- FSM and output registers live in the top module.

Test Plan:
- Single IMO request, sch_ready=1: arb_valid=1, arb_cmd=1, addr=0x123 at edge 0 -> sch_valid=1, sch_src=1, sch_addr=0x123 at edge 1; arb_ack pulse at edge 2 only.
- Contention, no lock: host_valid and arb_valid both held -> host granted first; IMO granted after host acks; no double grant.
- Starvation, MAX_WAIT=4: host_valid re-asserts every cycle after its ack, arb_valid held -> IMO granted after wait_cnt reaches 4, then wait_cnt reads 0.
- Lock sequence: IMO issues 3 commands with imo_lock=1, host_valid=1 throughout -> three consecutive IMO grants; host granted only after imo_lock drops.
- Lock timeout, LOCK_TIMEOUT=8: imo_lock=1, arb_valid=0, host_valid=1 -> host granted at timeout; lock_err=1 and stays 1 until rst_n.
- Backpressure and reset: sch_ready=0 for 5 cycles -> sch_* held stable, no ack. Pull rst_n low mid-ISSUE -> sch_valid=0 immediately, no ack pulse after release.
